// File: rtl/servo_pkg.sv
// servo_pkg: shared defaults, FSM state encoding and command record layout for the
// servo command sequencer (servo_cmd_seq, servo_cmd_fifo).
package servo_pkg;

    // Default configuration; FRAME_CYCLES_DEF is one 20 ms frame at 50 MHz.
    localparam int unsigned FRAME_CYCLES_DEF = 1000000;
    localparam int unsigned NUM_SERVO_DEF    = 4;
    localparam int unsigned FIFO_DEPTH_DEF   = 8;
    localparam int unsigned DWELL_W_DEF      = 8;

    // Sequencer FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;

    // A command record is packed as {mask, pos, dwell}, MSB to LSB.
    function automatic int unsigned cmd_width(input int unsigned num_servo,
                                              input int unsigned dwell_w);
        return 2 * num_servo + dwell_w;
    endfunction

endpackage

// File: rtl/servo_cmd_fifo.sv
// servo_cmd_fifo: synchronous FIFO holding packed {mask, pos, dwell} command records.
// Push is refused when full even if a pop happens in the same cycle; flush empties it
// and overrides any push or pop in that cycle.
module servo_cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy guards every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/servo_cmd_seq.sv
// servo_cmd_seq: frame-aligned command sequencer feeding the 4-channel servo PWM stage.
// Commands are buffered, applied only on a frame boundary, then held for 'dwell' extra frames.
// Optional build macro SERVO_SEQ_FLUSH_EN adds a synchronous i_flush input that empties the
// queue and returns the FSM to idle while s_out keeps its value.
module servo_cmd_seq
    import servo_pkg::*;
#(
    parameter int unsigned NUM_SERVO    = NUM_SERVO_DEF,
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int unsigned DWELL_W      = DWELL_W_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
`ifdef SERVO_SEQ_FLUSH_EN
    input  logic                          i_flush,
`endif
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [NUM_SERVO-1:0]          i_cmd_mask,
    input  logic [NUM_SERVO-1:0]          i_cmd_pos,
    input  logic [DWELL_W-1:0]            i_cmd_dwell,
    output logic [NUM_SERVO-1:0]          o_s_out,
    output logic                          o_frame_tick,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned CMD_W = cmd_width(NUM_SERVO, DWELL_W);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0]                r_frame_cnt;
    logic                            w_tick;
    logic [1:0]                      r_state;
    logic [1:0]                      w_state_nxt;
    logic [DWELL_W-1:0]              r_dwell_cnt;
    logic [DWELL_W-1:0]              w_dwell_nxt;
    logic [NUM_SERVO-1:0]            r_s_out;
    logic [NUM_SERVO-1:0]            w_s_nxt;
    logic                            w_flush;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_full;
    logic                            w_empty;
    logic [CMD_W-1:0]                w_head;
    logic [NUM_SERVO-1:0]            w_head_mask;
    logic [NUM_SERVO-1:0]            w_head_pos;
    logic [DWELL_W-1:0]              w_head_dwell;
    logic [$clog2(FIFO_DEPTH):0]     w_count;

`ifdef SERVO_SEQ_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_tick       = (r_frame_cnt == FRAME_LAST);
    assign o_cmd_ready  = ~w_full;
    assign w_push       = i_cmd_valid & o_cmd_ready;
    assign {w_head_mask, w_head_pos, w_head_dwell} = w_head;

    assign o_s_out      = r_s_out;
    assign o_frame_tick = w_tick;
    assign o_busy       = (r_state != ST_IDLE) | ~w_empty;
    assign o_fifo_level = w_count;

    servo_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({i_cmd_mask, i_cmd_pos, i_cmd_dwell}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Free-running frame counter, 0..FRAME_CYCLES-1; the last count is the frame tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_tick) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
    end

    // Next-state logic: commands are only applied and dwell only counts on frame ticks.
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell_cnt;
        w_s_nxt     = r_s_out;
        w_pop       = 1'b0;
        if (w_flush) begin
            w_state_nxt = ST_IDLE;
            w_dwell_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_tick && !w_empty) begin
                        w_pop       = 1'b1;
                        w_s_nxt     = (r_s_out & ~w_head_mask) | (w_head_pos & w_head_mask);
                        w_dwell_nxt = w_head_dwell;
                        w_state_nxt = (w_head_dwell == '0) ? ST_IDLE : ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (w_tick) begin
                        if (r_dwell_cnt == DWELL_W'(1)) begin
                            // Skip IDLE when work is queued so the next apply lands on
                            // the very next tick and spacing stays exactly dwell+1 frames.
                            w_dwell_nxt = '0;
                            w_state_nxt = w_empty ? ST_IDLE : ST_WAIT;
                        end else begin
                            w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM, dwell counter and output level registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_dwell_cnt <= '0;
            r_s_out     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_s_out     <= w_s_nxt;
        end
    end

endmodule
